// File: rtl/lr35902_bus_pkg.sv
// lr35902_bus_pkg: address map, timer tap table and overflow FSM states shared
// by the timer/high-RAM bus responder.
package lr35902_bus_pkg;

   localparam logic [15:0] ADR_DIV  = 16'hFF04;
   localparam logic [15:0] ADR_TIMA = 16'hFF05;
   localparam logic [15:0] ADR_TMA  = 16'hFF06;
   localparam logic [15:0] ADR_TAC  = 16'hFF07;
   localparam logic [15:0] HRAM_LO  = 16'hFF80;
   localparam logic [15:0] HRAM_HI  = 16'hFFFE;

   // sys_cnt bit watched by the timer, indexed by tac[1:0]
   localparam logic [3:0] TAC_TAP [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

   typedef enum logic [1:0] {OVF_IDLE, OVF_PEND, OVF_RELOAD} ovf_state_t;

   function automatic logic tap_sel(input logic [15:0] cnt, input logic [2:0] tac);
      return tac[2] & cnt[TAC_TAP[tac[1:0]]];
   endfunction

endpackage

// File: rtl/timer_core.sv
// timer_core: system divider, programmable timer with delayed TMA reload and
// one-clock interrupt pulse.
module timer_core
   import lr35902_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       div_wr,
   input  logic       tima_wr,
   input  logic       tma_wr,
   input  logic       tac_wr,
   input  logic [7:0] wdata,
   output logic [7:0] div,
   output logic [7:0] tima,
   output logic [7:0] tma,
   output logic [2:0] tac,
   output logic       irq_timer
);

   logic [15:0] sys_cnt, sys_nxt;
   logic [2:0]  tac_nxt;
   logic [7:0]  tma_nxt;
   logic [1:0]  cnt;
   logic        inc, reload, ovf;
   ovf_state_t  state;

   assign div = sys_cnt[15:8];

   // comparing sel before and after this edge catches drops caused by DIV/TAC writes too
   always_comb begin
      sys_nxt = div_wr ? 16'h0000 : sys_cnt + 16'd1;
      tac_nxt = tac_wr ? wdata[2:0] : tac;
      tma_nxt = tma_wr ? wdata : tma;
      inc     = tap_sel(sys_cnt, tac) & ~tap_sel(sys_nxt, tac_nxt);
      reload  = (state == OVF_PEND) && (cnt == 2'd0);
      ovf     = inc & ~tima_wr & ~reload & (tima == 8'hFF);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sys_cnt   <= 16'h0000;
         tima      <= 8'h00;
         tma       <= 8'h00;
         tac       <= 3'b000;
         cnt       <= 2'd0;
         state     <= OVF_IDLE;
         irq_timer <= 1'b0;
      end else begin
         sys_cnt   <= sys_nxt;
         tac       <= tac_nxt;
         tma       <= tma_nxt;
         irq_timer <= reload;
         tima      <= reload ? tma_nxt : tima_wr ? wdata : inc ? tima + 8'd1 : tima;
         if (reload)
            state <= OVF_RELOAD;
         else if (ovf) begin
            state <= OVF_PEND;
            cnt   <= 2'd3;
         end else if (state == OVF_PEND) begin
            state <= tima_wr ? OVF_IDLE : OVF_PEND;
            cnt   <= cnt - 2'd1;
         end else
            state <= OVF_IDLE;
      end
   end

endmodule

// File: rtl/io_timer_hram.sv
// io_timer_hram: bus responder for the timer registers (0xFF04-0xFF07) and
// high RAM (0xFF80-0xFFFE); zero-wait-state reads, writes on the strobe edge.
module io_timer_hram
   import lr35902_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] adr,
   input  logic [7:0]  din,
   input  logic        read,
   input  logic        write,
   output logic [7:0]  dout,
   output logic        doe,
   output logic        irq_timer
);

   logic [7:0] hram [0:126];
   logic [7:0] div, tima, tma, rdata;
   logic [2:0] tac;
   logic       hit_hram, hit;

   timer_core u_timer (
      .clk       (clk),
      .reset     (reset),
      .div_wr    (write && adr == ADR_DIV),
      .tima_wr   (write && adr == ADR_TIMA),
      .tma_wr    (write && adr == ADR_TMA),
      .tac_wr    (write && adr == ADR_TAC),
      .wdata     (din),
      .div       (div),
      .tima      (tima),
      .tma       (tma),
      .tac       (tac),
      .irq_timer (irq_timer)
   );

   always_comb begin
      hit_hram = (adr >= HRAM_LO) && (adr <= HRAM_HI);
      hit      = hit_hram || ((adr >= ADR_DIV) && (adr <= ADR_TAC));
      rdata    = adr == ADR_DIV  ? div :
                 adr == ADR_TIMA ? tima :
                 adr == ADR_TMA  ? tma :
                 adr == ADR_TAC  ? {5'b11111, tac} : hram[adr[6:0]];
      doe      = read & hit;
      dout     = doe ? rdata : 8'h00;
   end

   always_ff @(posedge clk)
      if (write && hit_hram)
         hram[adr[6:0]] <= din;

endmodule

// File: tb/tb_io_timer_hram.sv
// tb_io_timer_hram: directed checks of decode, HRAM, divider/timer counting,
// overflow reload timing, write collisions and reset during a pending reload.
module tb_io_timer_hram;

   logic        clk = 1'b0;
   logic        reset, read, write;
   logic [15:0] adr;
   logic [7:0]  din, dout;
   logic        doe, irq_timer;

   logic [7:0]  rdat;
   logic        roe, rirq;
   int          errors = 0;
   int          checks = 0;

   io_timer_hram dut (
      .clk       (clk),
      .reset     (reset),
      .adr       (adr),
      .din       (din),
      .read      (read),
      .write     (write),
      .dout      (dout),
      .doe       (doe),
      .irq_timer (irq_timer)
   );

   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      adr = a; din = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      adr = a; read = 1'b1;
      #1;
      rdat = dout; roe = doe; rirq = irq_timer;
      @(negedge clk);
      read = 1'b0;
   endtask

   // leaves the bench just after overflow edge N with TMA=0xF0
   task automatic ovf_setup(input logic [7:0] tac_val, input int n);
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF06, 8'hF0);
      wr(16'hFF05, 8'hFF);
      wr(16'hFF07, tac_val);
      idle(n);
   endtask

   task automatic test_reset;
      rd(16'hFF07);
      checks++;
      if (rdat !== 8'hF8 || roe !== 1'b1) begin
         errors++; $display("FAIL reset_tac got=%h/%b want=f8/1", rdat, roe);
      end
      rd(16'h1234);
      checks++;
      if (rdat !== 8'h00 || roe !== 1'b0) begin
         errors++; $display("FAIL unmapped got=%h/%b want=00/0", rdat, roe);
      end
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL reset_tima got=%h want=00", rdat);
      end
   endtask

   task automatic test_hram;
      wr(16'hFF80, 8'h5A);
      wr(16'hFFFE, 8'hA5);
      wr(16'hFFFF, 8'h12);
      rd(16'hFF80);
      checks++;
      if (rdat !== 8'h5A || roe !== 1'b1) begin
         errors++; $display("FAIL hram_lo got=%h/%b want=5a/1", rdat, roe);
      end
      rd(16'hFFFE);
      checks++;
      if (rdat !== 8'hA5 || roe !== 1'b1) begin
         errors++; $display("FAIL hram_hi got=%h/%b want=a5/1", rdat, roe);
      end
      rd(16'hFFFF);
      checks++;
      if (rdat !== 8'h00 || roe !== 1'b0) begin
         errors++; $display("FAIL ffff got=%h/%b want=00/0", rdat, roe);
      end
      rd(16'hFF7F);
      checks++;
      if (roe !== 1'b0) begin
         errors++; $display("FAIL ff7f_doe got=%b want=0", roe);
      end
   endtask

   task automatic test_div_tap;
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF05, 8'h00);
      wr(16'hFF07, 8'h05);
      idle(160);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h0A) begin
         errors++; $display("FAIL tima_160 got=%h want=0a", rdat);
      end
      idle(4);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h0A) begin
         errors++; $display("FAIL tima_hold got=%h want=0a", rdat);
      end
      wr(16'hFF04, 8'h99);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h0B) begin
         errors++; $display("FAIL div_wr_inc got=%h want=0b", rdat);
      end
      rd(16'hFF04);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL div_clear got=%h want=00", rdat);
      end
   endtask

   task automatic test_overflow;
      ovf_setup(8'h05, 13);
      for (int i = 0; i < 6; i++) begin
         rd(16'hFF05);
         checks++;
         if (rdat !== (i < 4 ? 8'h00 : 8'hF0) || rirq !== (i == 4)) begin
            errors++;
            $display("FAIL ovf[%0d] got=%h/%b want=%h/%b", i, rdat, rirq, i < 4 ? 8'h00 : 8'hF0, i == 4);
         end
      end
   endtask

   task automatic test_abort;
      ovf_setup(8'h05, 13);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL abort_pend got=%h want=00", rdat);
      end
      wr(16'hFF05, 8'h33);
      for (int i = 0; i < 5; i++) begin
         rd(16'hFF05);
         checks++;
         if (rdat !== 8'h33 || rirq !== 1'b0) begin
            errors++; $display("FAIL abort[%0d] got=%h/%b want=33/0", i, rdat, rirq);
         end
      end
   endtask

   task automatic test_tma_reload;
      ovf_setup(8'h05, 13);
      idle(3);
      wr(16'hFF06, 8'h77);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h77 || rirq !== 1'b1) begin
         errors++; $display("FAIL tma_reload got=%h/%b want=77/1", rdat, rirq);
      end
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h77 || rirq !== 1'b0) begin
         errors++; $display("FAIL tma_after got=%h/%b want=77/0", rdat, rirq);
      end
   endtask

   task automatic test_tima_reload_ignored;
      ovf_setup(8'h05, 13);
      idle(3);
      wr(16'hFF05, 8'h55);
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'hF0 || rirq !== 1'b1) begin
         errors++; $display("FAIL tima_ignored got=%h/%b want=f0/1", rdat, rirq);
      end
   endtask

   task automatic test_reset_pend;
      ovf_setup(8'h04, 1021);
      rd(16'hFF04);
      checks++;
      if (rdat !== 8'h04) begin
         errors++; $display("FAIL pre_reset_div got=%h want=04", rdat);
      end
      rd(16'hFF05);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL pre_reset_pend got=%h want=00", rdat);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd(16'hFF04);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL post_reset_div got=%h want=00", rdat);
      end
      rd(16'hFF06);
      checks++;
      if (rdat !== 8'h00) begin
         errors++; $display("FAIL post_reset_tma got=%h want=00", rdat);
      end
      for (int i = 0; i < 6; i++) begin
         rd(16'hFF05);
         checks++;
         if (rdat !== 8'h00 || rirq !== 1'b0) begin
            errors++; $display("FAIL post_reset[%0d] got=%h/%b want=00/0", i, rdat, rirq);
         end
      end
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; adr = 16'h0000; din = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset;
      test_hram;
      test_div_tap;
      test_overflow;
      test_abort;
      test_tma_reload;
      test_tima_reload_ignored;
      test_reset_pend;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
